// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared delay/impulse memory port.
// Port A (audio datapath) has priority; port B gets a slot after FAIR_LIMIT consecutive A grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FAIR_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       impulses,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic              b_err,
    output logic              b_err_sticky,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CMP_W = (ADDR_W > 16) ? ADDR_W : 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_owner_b;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic              r_b_err;
    logic              r_b_err_sticky;
    logic [7:0]        r_starve;

    logic              w_can_accept;
    logic              w_pick_b;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_b_illegal;
    logic              w_b_reject;
    logic              w_rd_accept;
    logic [CMP_W-1:0]  w_b_addr_x;
    logic [CMP_W-1:0]  w_imp_x;

    always_comb begin
        w_b_addr_x   = CMP_W'(b_addr);
        w_imp_x      = CMP_W'(impulses);
        w_b_illegal  = b_we && (w_b_addr_x >= w_imp_x);
        w_can_accept = (r_state == ST_IDLE) || mem_ready;
        w_pick_b     = b_req && ((r_starve == 8'(FAIR_LIMIT)) || !a_req);
        w_b_gnt      = rst_n && w_can_accept && w_pick_b;
        w_a_gnt      = rst_n && w_can_accept && a_req && !w_pick_b;
        w_b_reject   = w_b_gnt && w_b_illegal;
        w_rd_accept  = r_mem_en && !r_mem_we && mem_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_owner_b      <= 1'b0;
            r_a_rvalid     <= 1'b0;
            r_b_rvalid     <= 1'b0;
            r_b_err        <= 1'b0;
            r_b_err_sticky <= 1'b0;
            r_starve       <= '0;
        end else begin
            // Read ownership was latched at issue, so a stalled accept still routes correctly
            r_a_rvalid <= w_rd_accept && !r_owner_b;
            r_b_rvalid <= w_rd_accept && r_owner_b;
            r_b_err    <= w_b_reject;
            if (w_b_reject) begin
                r_b_err_sticky <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_ISSUE: begin
                    if (w_can_accept) begin
                        if (w_a_gnt) begin
                            r_state     <= ST_ISSUE;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= a_we;
                            r_mem_addr  <= a_addr;
                            r_mem_wdata <= a_wdata;
                            r_owner_b   <= 1'b0;
                        end else if (w_b_gnt && !w_b_illegal) begin
                            r_state     <= ST_ISSUE;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= b_we;
                            r_mem_addr  <= b_addr;
                            r_mem_wdata <= b_wdata;
                            r_owner_b   <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_mem_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                end
            endcase

            if (!b_req || w_b_gnt) begin
                r_starve <= '0;
            end else if (w_a_gnt && (r_starve != 8'(FAIR_LIMIT))) begin
                r_starve <= r_starve + 8'd1;
            end
        end
    end

    assign a_gnt        = w_a_gnt;
    assign b_gnt        = w_b_gnt;
    assign a_rvalid     = r_a_rvalid;
    assign b_rvalid     = r_b_rvalid;
    assign b_err        = r_b_err;
    assign b_err_sticky = r_b_err_sticky;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

    // Read data goes straight to both sinks; rvalid qualifies it.
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a driver predicts grants from the
// arbitration rules and queues expected memory transactions; a monitor checks DUT outputs.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int FL = 8;
    localparam int NCYC = 2400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   impulses = 16'h0010;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] mem_rdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, b_err, b_err_sticky;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_LIMIT(FL)) dut (
        .clk(clk), .rst_n(rst_n), .impulses(impulses),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_err_sticky(b_err_sticky),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            owner_b;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } tx_t;

    tx_t issue_q[$];
    tx_t cur;
    bit  cur_v = 0;
    bit  mon_on = 0;
    bit  exp_a_gnt = 0, exp_b_gnt = 0;
    bit  exp_err_next = 0, exp_err_now = 0, exp_sticky = 0;
    bit  exp_rv_a = 0, exp_rv_b = 0;
    int  starve = 0;
    int  n_chk = 0, n_fail = 0;
    int  n_b_err_seen = 0, n_rd_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Memory model: random read data every cycle, only meaningful when rvalid is high.
    always @(posedge clk) mem_rdata <= DW'($urandom);

    // Monitor: compares this cycle's outputs, then advances the presented-slot model.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("a_gnt", 32'(a_gnt), 32'(exp_a_gnt));
            chk("b_gnt", 32'(b_gnt), 32'(exp_b_gnt));
            chk("mem_en", 32'(mem_en), 32'(cur_v));
            if (cur_v) begin
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
            end
            chk("a_rvalid", 32'(a_rvalid), 32'(exp_rv_a));
            chk("b_rvalid", 32'(b_rvalid), 32'(exp_rv_b));
            chk("b_err", 32'(b_err), 32'(exp_err_now));
            chk("b_err_sticky", 32'(b_err_sticky), 32'(exp_sticky));
            if (!rst_n) begin
                issue_q.delete();
                cur_v = 0;
                exp_rv_a = 0;
                exp_rv_b = 0;
                exp_err_now = 0;
                exp_err_next = 0;
                exp_sticky = 0;
            end else begin
                exp_rv_a = 0;
                exp_rv_b = 0;
                if (cur_v && mem_ready) begin
                    if (!cur.we) begin
                        n_rd_seen++;
                        if (cur.owner_b) exp_rv_b = 1; else exp_rv_a = 1;
                    end
                    cur_v = 0;
                end
                exp_err_now = exp_err_next;
                if (exp_err_next) begin
                    exp_sticky = 1;
                    n_b_err_seen++;
                end
                exp_err_next = 0;
                if (issue_q.size() > 0) begin
                    cur = issue_q.pop_front();
                    cur_v = 1;
                end
            end
        end
    end

    // Driver plus arbitration reference: who should win given pending requests and fairness count.
    initial begin
        int pa, pb, pr, prst;
        bit can;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            mon_on = 1;
            if (a_req && exp_a_gnt) a_req = 0;
            if (b_req && exp_b_gnt) b_req = 0;

            if (cyc < 600)       begin pa = 50;  pb = 30;  pr = 75;  prst = 0; end
            else if (cyc < 900)  begin pa = 100; pb = 100; pr = 100; prst = 0; end
            else if (cyc < 1300) begin pa = 70;  pb = 60;  pr = 30;  prst = 0; end
            else                 begin pa = 60;  pb = 50;  pr = 80;  prst = 2; end

            rst_n = !(cyc < 3 || $urandom_range(99) < prst);
            if (!a_req && $urandom_range(99) < pa) begin
                a_req = 1;
                a_we = 1'($urandom_range(1));
                a_addr = AW'($urandom);
                a_wdata = DW'($urandom);
            end
            if (!b_req && $urandom_range(99) < pb) begin
                b_req = 1;
                b_we = 1'($urandom_range(1));
                b_wdata = DW'($urandom);
                case ($urandom_range(3))
                    0: b_addr = impulses - 16'd1;
                    1: b_addr = impulses;
                    2: b_addr = AW'($urandom_range(63));
                    default: b_addr = AW'($urandom);
                endcase
            end
            if ($urandom_range(99) < 5) impulses = 16'($urandom_range(64));
            mem_ready = ($urandom_range(99) < pr);

            #1;
            exp_a_gnt = 0;
            exp_b_gnt = 0;
            if (rst_n) begin
                can = !cur_v || mem_ready;
                if (can && b_req && (starve == FL || !a_req)) exp_b_gnt = 1;
                else if (can && a_req) exp_a_gnt = 1;
                if (exp_b_gnt) begin
                    if (b_we && (b_addr >= impulses)) exp_err_next = 1;
                    else issue_q.push_back('{1'b1, b_we, b_addr, b_wdata});
                end else if (exp_a_gnt) begin
                    issue_q.push_back('{1'b0, a_we, a_addr, a_wdata});
                end
                if (!b_req || exp_b_gnt) starve = 0;
                else if (exp_a_gnt && starve < FL) starve++;
            end else begin
                starve = 0;
            end
        end
        @(posedge clk);
        #3;
        chk("b_err_events_seen", 32'(n_b_err_seen > 0), 32'd1);
        chk("reads_seen", 32'(n_rd_seen > 0), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single delay/impulse memory port (on-chip SRAM or off-chip memory behind its ready handshake) between two requesters. Port A is the real-time audio convolution datapath; port B is the host/configuration path that loads impulse coefficients and reads back memory. A has priority, with a bounded-starvation guarantee for B. B writes are restricted to the impulse coefficient region.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- FAIR_LIMIT, 8, consecutive A grants allowed while B is pending before B is forced a slot (range 1..255)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- impulses  in  16  coefficient region size; legal B write addresses are 0..impulses-1
- a_req  in  1  A request; held with a_we/a_addr/a_wdata until a_gnt
- a_we  in  1  A write (1) / read (0)
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  combinational; A request accepted this cycle
- a_rvalid  out  1  registered; mem_rdata holds A read data this cycle
- b_req, b_we, b_addr, b_wdata  in  1/1/ADDR_W/DATA_W  B request, same rules as A
- b_gnt  out  1  combinational; B request accepted or rejected this cycle
- b_rvalid  out  1  registered; mem_rdata holds B read data this cycle
- b_err  out  1  registered one-cycle pulse; B write rejected
- b_err_sticky  out  1  set by any b_err, cleared only by reset
- mem_en  out  1  registered; transaction presented to memory
- mem_we  out  1  registered write strobe, valid with mem_en
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_ready  in  1  memory accepts the presented transaction (tie 1 for SRAM)
- mem_rdata  in  DATA_W  read data, valid one cycle after a read is accepted; routed to both a and b data sinks

## Operation
- States: IDLE (nothing presented), ISSUE (mem_en=1, awaiting mem_ready).
- can_accept = (state==IDLE) or (state==ISSUE and mem_ready).
- Arbitration while can_accept: if b_req and (starve_cnt==FAIR_LIMIT or !a_req) then B, else if a_req then A, else none. Exactly one gnt per cycle; never both.
- Granted legal request: registered into mem_* at the next edge; state becomes ISSUE. Same-edge accept plus new grant means back-to-back issue: one transaction per cycle when mem_ready stays 1.
- No grant while can_accept: state becomes IDLE, mem_en=0; mem_addr/mem_wdata hold their last value.
- ISSUE with mem_ready=0: all mem_* held stable; no gnt.
- Accepted read (mem_en & !mem_we & mem_ready at an edge): the owner's rvalid is 1 in the next cycle only. Owner is recorded at issue, not at accept.
- B illegal write (b_we and b_addr >= impulses): b_gnt pulses, transaction dropped. b_err and b_err_sticky are set at the next edge. The slot is consumed: mem_en=0 the next cycle and A is not granted that cycle. B reads are legal at any address.
- starve_cnt (8 bit): +1 on each A grant while b_req=1, saturating at FAIR_LIMIT. Cleared on B grant or whenever b_req=0.
- impulses is sampled at B grant time; changes affect only later requests.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; mem_en, mem_we, mem_addr, mem_wdata, a_rvalid, b_rvalid, b_err, b_err_sticky, starve_cnt all 0. Any in-flight transaction or pending rvalid is discarded. a_gnt/b_gnt are 0 while rst_n=0.
- Grant latency: 0 cycles (combinational) from req when can_accept.
- Issue latency: mem_en is 1 in the cycle after gnt.
- Read latency: rvalid is 1 in the cycle after the accept edge, giving a minimum of 2 cycles from gnt to rvalid with mem_ready=1.
- Simultaneous a_req and b_req with starve_cnt<FAIR_LIMIT: A wins. With starve_cnt==FAIR_LIMIT: B wins.
- Requester rule: a request whose gnt is 1 at an edge is consumed. Keeping req high afterwards is a new request.

## Test plan
- Single A read, addr 0x0010, mem_ready=1: a_gnt in cycle 0; mem_en=1, mem_addr=0x0010 in cycle 1; a_rvalid=1 in cycle 2 only; b_rvalid stays 0.
- A and B both requesting continuously, FAIR_LIMIT=8: pattern of 8 A grants then 1 B grant, repeating; never both gnt in one cycle.
- B write addr 0x0020 with impulses=0x0010: b_gnt=1; next cycle b_err=1, b_err_sticky=1, mem_en=0. The same write to 0x000F issues normally with mem_we=1.
- mem_ready held low 3 cycles during an A write, B requesting: mem_* stable for all 3 cycles, no gnt. Accept on the 4th cycle, with b_gnt that same cycle.
- Back-to-back A reads 0x0100..0x0103, mem_ready=1: four consecutive mem_en cycles; a_rvalid high for four consecutive cycles starting 2 cycles after the first gnt.
- rst_n low during ISSUE of a read: the next cycle has mem_en=0 and no rvalid; b_err_sticky cleared; after release, the first grant behaves as from IDLE.
